// File: rtl/ledtube_pkg.sv
// Shared digit codes and active-high 7-segment glyphs {dp,g,f,e,d,c,b,a}.
package ledtube_pkg;
  localparam logic [3:0] DIGIT_MINUS = 4'hA;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  localparam logic [7:0] GLYPH_0     = 8'h3F;
  localparam logic [7:0] GLYPH_1     = 8'h06;
  localparam logic [7:0] GLYPH_2     = 8'h5B;
  localparam logic [7:0] GLYPH_3     = 8'h4F;
  localparam logic [7:0] GLYPH_4     = 8'h66;
  localparam logic [7:0] GLYPH_5     = 8'h6D;
  localparam logic [7:0] GLYPH_6     = 8'h7D;
  localparam logic [7:0] GLYPH_7     = 8'h07;
  localparam logic [7:0] GLYPH_8     = 8'h7F;
  localparam logic [7:0] GLYPH_9     = 8'h6F;
  localparam logic [7:0] GLYPH_MINUS = 8'h40;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;
endpackage

// File: rtl/ledtube_seg7_decode.sv
// Combinational digit code to active-high glyph; 0xB-0xF decode as blank.
module seg7_decode
  import ledtube_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] glyph
);
  always_comb begin
    glyph = GLYPH_BLANK;
    case (code)
      4'd0:        glyph = GLYPH_0;
      4'd1:        glyph = GLYPH_1;
      4'd2:        glyph = GLYPH_2;
      4'd3:        glyph = GLYPH_3;
      4'd4:        glyph = GLYPH_4;
      4'd5:        glyph = GLYPH_5;
      4'd6:        glyph = GLYPH_6;
      4'd7:        glyph = GLYPH_7;
      4'd8:        glyph = GLYPH_8;
      4'd9:        glyph = GLYPH_9;
      DIGIT_MINUS: glyph = GLYPH_MINUS;
      default:     glyph = GLYPH_BLANK;
    endcase
  end
endmodule

// File: rtl/ledtube_scan.sv
// Multiplexed 7-segment scan driver: digit shift buffer, prescaled scan,
// registered one-hot select and segment bus with configurable polarity.
module ledtube_scan
  import ledtube_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIV         = 12500,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit SEL_ACT_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [3:0]            digit_in,
  input  logic                  clear,
  output logic [NUM_DIGITS-1:0] sel,
  output logic [7:0]            seg,
  output logic [3:0]            fill
);
  localparam int PW = $clog2(DIV);
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]         psc;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic                  tick;
  logic [3:0]            dig_buf [NUM_DIGITS];
  logic [7:0]            glyph;
  logic [NUM_DIGITS-1:0] onehot;

  assign tick = (psc == PW'(DIV - 1));

  // Outputs are registered from the index value taking effect on the same
  // edge, so sel/seg move exactly when the scan advances.
  always_comb begin
    idx_nxt = idx;
    if (tick) begin
      idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  assign onehot = NUM_DIGITS'(1) << idx_nxt;

  seg7_decode u_decode (
    .code  (dig_buf[idx_nxt]),
    .glyph (glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      psc <= '0;
      idx <= '0;
      sel <= SEL_ACT_LOW ? ~NUM_DIGITS'(1) : NUM_DIGITS'(1);
      seg <= SEG_ACT_LOW ? 8'hFF : 8'h00;
    end else begin
      psc <= tick ? '0 : psc + 1'b1;
      idx <= idx_nxt;
      sel <= SEL_ACT_LOW ? ~onehot : onehot;
      seg <= SEG_ACT_LOW ? ~glyph : glyph;
    end
  end

  // Clear has priority over a coincident push.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) dig_buf[i] <= DIGIT_BLANK;
      fill <= '0;
    end else if (push) begin
      for (int i = 1; i < NUM_DIGITS; i++) dig_buf[i] <= dig_buf[i-1];
      dig_buf[0] <= digit_in;
      if (fill != 4'(NUM_DIGITS)) fill <= fill + 4'd1;
    end
  end
endmodule

// File: tb/tb_ledtube_scan.sv
// Drives a 4-digit active-low and an 8-digit active-high instance side by side
// against a per-cycle reference model of buffer, fill and scan position.
module tb_ledtube_scan;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic [3:0] digit_in = 4'h0;
  logic       clear = 1'b0;
  logic [3:0] sel4;
  logic [7:0] seg4;
  logic [3:0] fill4;
  logic [7:0] sel8;
  logic [7:0] seg8;
  logic [3:0] fill8;

  always #5 clk = ~clk;

  ledtube_scan #(.NUM_DIGITS(4), .DIV(DIV), .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b1)) dut4 (
    .clk(clk), .rst(rst), .push(push), .digit_in(digit_in), .clear(clear),
    .sel(sel4), .seg(seg4), .fill(fill4)
  );

  ledtube_scan #(.NUM_DIGITS(8), .DIV(DIV), .SEG_ACT_LOW(1'b0), .SEL_ACT_LOW(1'b0)) dut8 (
    .clk(clk), .rst(rst), .push(push), .digit_in(digit_in), .clear(clear),
    .sel(sel8), .seg(seg8), .fill(fill8)
  );

  int passed = 0;
  int total  = 0;

  // Reference state: k=0 is the 4-digit active-low unit, k=1 the 8-digit one.
  int         nd [2] = '{4, 8};
  bit         low [2] = '{1'b1, 1'b0};
  logic [3:0] m_buf [2][8];
  int         m_fill [2];
  logic [7:0] m_seg [2];
  int         m_t;

  logic [7:0] glyph_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic logic [7:0] glyph_al(input logic [3:0] code);
    if (code < 4'd10) return glyph_tbl[code];
    if (code == 4'hA) return 8'hBF;
    return 8'hFF;
  endfunction

  function automatic int cur_digit(input int k);
    return (m_t / DIV) % nd[k];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, obs, exp);
  endtask

  task automatic model_update(input bit p, input logic [3:0] d, input bit c, input bit r);
    if (r) begin
      m_t = 0;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 8; i++) m_buf[k][i] = 4'hF;
        m_fill[k] = 0;
        m_seg[k] = low[k] ? 8'hFF : 8'h00;
      end
    end else begin
      m_t++;
      for (int k = 0; k < 2; k++) begin
        logic [7:0] g;
        g = glyph_al(m_buf[k][cur_digit(k)]);
        m_seg[k] = low[k] ? g : ~g;
        if (c) begin
          for (int i = 0; i < 8; i++) m_buf[k][i] = 4'hF;
          m_fill[k] = 0;
        end else if (p) begin
          for (int i = nd[k] - 1; i > 0; i--) m_buf[k][i] = m_buf[k][i-1];
          m_buf[k][0] = d;
          if (m_fill[k] < nd[k]) m_fill[k]++;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] oh;
    oh = 8'(1) << cur_digit(0);
    chk("sel4", {4'h0, sel4}, ~oh & 8'h0F);
    chk("seg4", seg4, m_seg[0]);
    chk("fill4", {4'h0, fill4}, 8'(m_fill[0]));
    oh = 8'(1) << cur_digit(1);
    chk("sel8", sel8, oh);
    chk("seg8", seg8, m_seg[1]);
    chk("fill8", {4'h0, fill8}, 8'(m_fill[1]));
  endtask

  task automatic step(input bit p, input logic [3:0] d, input bit c, input bit r);
    push = p; digit_in = d; clear = c; rst = r;
    @(posedge clk);
    model_update(p, d, c, r);
    #1;
    check_all();
    push = 1'b0; clear = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and an empty frame rotating through all digits.
    step(1'b0, 4'h0, 1'b0, 1'b1);
    chk("rst_sel4", {4'h0, sel4}, 8'h0E);
    chk("rst_seg4", seg4, 8'hFF);
    chk("rst_fill4", {4'h0, fill4}, 8'h00);
    idle(18);

    // Fill the buffer with 1,2,3,4 then overflow with 5.
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    chk("fill_full", {4'h0, fill4}, 8'h04);
    idle(16);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    chk("fill_sat", {4'h0, fill4}, 8'h04);
    idle(16);

    // Minus sign and blank codes.
    step(1'b1, 4'hA, 1'b0, 1'b0);
    step(1'b1, 4'hC, 1'b0, 1'b0);
    idle(16);

    // Coincident push and clear: clear wins.
    step(1'b1, 4'h7, 1'b1, 1'b0);
    chk("clr_fill4", {4'h0, fill4}, 8'h00);
    idle(16);

    // Reset mid-dwell on digit 2, then the first advance after a full dwell.
    step(1'b1, 4'h3, 1'b0, 1'b0);
    begin
      int guard = 0;
      while (!(cur_digit(0) == 2 && (m_t % DIV) == 1) && guard < 64) begin
        idle(1);
        guard++;
      end
      chk("mid_dwell_reach", 8'(guard < 64), 8'h01);
    end
    step(1'b0, 4'h0, 1'b0, 1'b1);
    chk("mrst_sel4", {4'h0, sel4}, 8'h0E);
    chk("mrst_seg4", seg4, 8'hFF);
    idle(3);
    chk("mrst_hold", {4'h0, sel4}, 8'h0E);
    idle(1);
    chk("mrst_adv", {4'h0, sel4}, 8'h0D);

    // Active-high unit shows an 8 on digit 0.
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b1, 4'h8, 1'b0, 1'b0);
    idle(1);
    chk("ah_seg8", seg8, 8'h7F);
    chk("ah_sel8", sel8, 8'h01);
    idle(32);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      bit p, c, r;
      p = ($urandom_range(2) == 0);
      c = ($urandom_range(19) == 0);
      r = ($urandom_range(99) == 0);
      step(p, 4'($urandom_range(15)), c, r);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
